adc_sampler: RTL and testbench
==============================

Name: adc_sampler

Overview:
- Behavioural/synthesizable ADC front end that sits directly upstream of the transient stream capture core.
- Answers the core's `req` line with conversion results on `dat`, each flagged by a one-cycle `rdy` strobe.
- Samples come from a 16-entry, host-writable sample memory that is played back cyclically.
- Gives the capture core a deterministic, repeatable input stream for simulation and for FPGA bring-up.

Parameters:
- CONV_CYCLES, 4: clock cycles spent in conversion per sample; legal range 1..255.
- DEPTH_LOG2, 4: log2 of sample memory depth; default gives 16 entries.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  conversion request from the capture core; level-sensitive.
- rdy  out  1  one-cycle strobe; `dat` is valid in that same cycle.
- dat  out  8  conversion result; held between strobes.
- busy  out  1  high while a conversion is in progress (CONV state).
- wr_en  in  1  sample memory write enable.
- wr_addr  in  DEPTH_LOG2  sample memory write address.
- wr_data  in  8  sample memory write data.
- sample_cnt  out  16  count of completed conversions; saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State → IDLE.
  - rdy=0, busy=0, dat=8'h00, sample_cnt=0.
  - Playback index idx=0; delay counter=0.
  - All memory entries cleared to 8'h00.
  - A write presented during reset is ignored.
  - Reset mid-conversion aborts it; no rdy is produced.
- State machine: IDLE, CONV, DONE. All outputs are registered.
- IDLE:
  - rdy=0, busy=0.
  - If req==1 at an edge → CONV, delay counter loaded with CONV_CYCLES-1.
- CONV:
  - busy=1.
  - Each edge: if req==0 → IDLE (abort; idx, dat and sample_cnt unchanged).
  - Else if counter==0 → DONE; else counter decrements.
  - CONV therefore lasts exactly CONV_CYCLES cycles.
- DONE entry edge:
  - dat ← mem[idx].
  - idx ← (idx+1) mod 2^DEPTH_LOG2; wraps 15→0.
  - sample_cnt ← sample_cnt+1, unless already 16'hFFFF.
  - rdy=1 and busy=0 for exactly this one cycle.
- DONE exit:
  - If req==1 → CONV, counter reloaded (back-to-back streaming).
  - Else → IDLE.
- Latency: req first sampled high at edge N → rdy high in the cycle after edge N+CONV_CYCLES.
- Streaming period: CONV_CYCLES+1 cycles per sample while req stays high.
- req is never required to drop between samples; the capture core may hold it continuously.
- rdy is never asserted on two consecutive cycles.
- Memory write:
  - If wr_en==1 at an edge (reset high): mem[wr_addr] ← wr_data. Allowed in any state.
  - Collision (write to mem[idx] on the same edge that enters DONE): dat receives the OLD entry (read-before-write); the new value is seen on the next wrap.
- dat changes only on DONE entry or reset; an aborted conversion never alters dat.
- No combinational path from req to any output.

Test Plan:
- Reset, all memory zero, req=0 for 10 cycles → rdy=0, busy=0, dat=00, sample_cnt=0 throughout.
- CONV_CYCLES=4; write mem[0]=8'h0A, mem[1]=8'h99; raise req at edge N and hold it:
  - busy high for 4 cycles.
  - rdy pulse after edge N+4 with dat=0A.
  - Second rdy 5 cycles later with dat=99.
  - sample_cnt=2.
- Preload mem[0..15]=00,0A,99,9B,93,D5,97,90,9F,D7,8D,9C,85,8A,91,8C; hold req for 17 conversions:
  - dat sequence matches the table, then 17th value = 00 (wrap).
  - sample_cnt=17.
  - 17 single-cycle rdy pulses, none adjacent.
- Drop req after 2 CONV cycles:
  - IDLE next cycle, no rdy, dat and sample_cnt unchanged.
  - Re-raise req → next conversion returns the same idx entry.
- Write mem[idx]=8'hD5 on the DONE-entry edge when the old value is 8'h93:
  - dat=93 now.
  - After 16 further conversions dat=D5.
- Assert reset (0) mid-CONV with wr_en=1:
  - Next cycle: IDLE, dat=00, sample_cnt=0, idx=0, no rdy, write discarded (memory all 00).

Source files
------------

// File: rtl/adc_sampler_if.sv
// adc_sampler_if: request/result and sample-memory write bundle for adc_sampler.
//   req        capture core -> sampler, level-sensitive conversion request
//   rdy        sampler -> core, one-cycle strobe qualifying dat
//   dat        sampler -> core, conversion result (held between strobes)
//   busy       sampler -> core, conversion in progress
//   wr_en/wr_addr/wr_data  host -> sampler, sample memory write port
//   sample_cnt sampler -> host, saturating count of completed conversions
interface adc_sampler_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  req;
  logic                  rdy;
  logic [7:0]            dat;
  logic                  busy;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic [15:0]           sample_cnt;

  modport master (
    output req, wr_en, wr_addr, wr_data,
    input  rdy, dat, busy, sample_cnt
  );

  modport slave (
    input  req, wr_en, wr_addr, wr_data,
    output rdy, dat, busy, sample_cnt
  );
endinterface

// File: rtl/adc_sampler.sv
// adc_sampler: deterministic ADC front end feeding the stream capture core.
// Each request spends CONV_CYCLES in CONV, then returns the next entry of a
// host-writable sample memory (played back cyclically) with a one-cycle rdy.
//   clk    rising-edge system clock
//   reset  synchronous, active-low
//   bus    adc_sampler_if.slave (req/rdy/dat/busy, memory write port, sample_cnt)
// All outputs come straight from flops; req only feeds next-state logic.
module adc_sampler #(
  parameter int CONV_CYCLES = 4,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic          clk,
  input  logic          reset,
  adc_sampler_if.slave  bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]            dat_q, dat_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic [15:0]           sample_cnt_q, sample_cnt_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dat_d        = dat_q;
    sample_cnt_d = sample_cnt_q;
    rdy_d        = 1'b0;
    busy_d       = 1'b0;
    mem_d        = mem_q;

    // Write lands on the same edge as a DONE-entry read of mem_q, so a
    // collision hands out the old entry (read-before-write).
    if (bus.wr_en) mem_d[bus.wr_addr] = bus.wr_data;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = CONV;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        if (!bus.req) begin
          state_d = IDLE;                       // abort: nothing consumed
        end else if (cnt_q == 8'd0) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          dat_d   = mem_q[idx_q];
          idx_d   = idx_q + 1'b1;               // natural wrap at DEPTH
          if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
        end else begin
          cnt_d  = cnt_q - 8'd1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.req) begin
          state_d = CONV;                       // back-to-back streaming
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      dat_q        <= '0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      sample_cnt_q <= '0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dat_q        <= dat_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      sample_cnt_q <= sample_cnt_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.rdy        = rdy_q;
  assign bus.busy       = busy_q;
  assign bus.dat        = dat_q;
  assign bus.sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: directed bench for adc_sampler with CONV_CYCLES=4, 16 entries.
module tb_adc_sampler;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  int   n;

  logic [7:0] tbl [16] = '{8'h00, 8'h0A, 8'h99, 8'h9B, 8'h93, 8'hD5, 8'h97, 8'h90,
                           8'h9F, 8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C};
  logic [7:0] mdl [16];

  adc_sampler_if #(.DEPTH_LOG2(4)) bus ();

  adc_sampler #(.CONV_CYCLES(4), .DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  // Cycles until the next rdy strobe, or -1 if none within the budget.
  task automatic wait_rdy(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.rdy && cyc < 50);
    if (!bus.rdy) cyc = -1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"},  32'(bus.rdy),  32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; bus.req = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    step(); step();
    reset = 1'b1;

    // Reset state held for 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      chk_idle("rst");
      chk("rst_dat", 32'(bus.dat), 32'h00);
      chk("rst_cnt", 32'(bus.sample_cnt), 32'd0);
      step();
    end

    // Latency and streaming period, two samples
    wr(4'd0, 8'h0A);
    wr(4'd1, 8'h99);
    bus.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("c1_busy", 32'(bus.busy), 32'd1);
      chk("c1_rdy",  32'(bus.rdy),  32'd0);
    end
    step();
    chk("s1_rdy",  32'(bus.rdy),  32'd1);
    chk("s1_busy", 32'(bus.busy), 32'd0);
    chk("s1_dat",  32'(bus.dat),  32'h0A);
    chk("s1_cnt",  32'(bus.sample_cnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("c2_busy", 32'(bus.busy), 32'd1);
      chk("c2_rdy",  32'(bus.rdy),  32'd0);
    end
    step();
    chk("s2_rdy", 32'(bus.rdy), 32'd1);
    chk("s2_dat", 32'(bus.dat), 32'h99);
    chk("s2_cnt", 32'(bus.sample_cnt), 32'd2);
    bus.req = 1'b0;
    step();
    chk_idle("s2_exit");

    // Full table playback with wrap, 17 conversions
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = tbl[i];
      wr(4'(i), tbl[i]);
    end
    bus.req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_rdy(n);
      chk("tbl_period", 32'(n), 32'd5);
      chk("tbl_dat", 32'(bus.dat), 32'(mdl[i % 16]));
    end
    chk("tbl_cnt", 32'(bus.sample_cnt), 32'd17);
    bus.req = 1'b0;
    step();
    chk_idle("tbl_exit");

    // Abort after 2 CONV cycles
    bus.req = 1'b1;
    wait_rdy(n);
    chk("ab_pre_dat", 32'(bus.dat), 32'h0A);
    chk("ab_pre_cnt", 32'(bus.sample_cnt), 32'd18);
    bus.req = 1'b0;
    step();
    bus.req = 1'b1;
    step();
    step();
    chk("ab_busy_in", 32'(bus.busy), 32'd1);
    bus.req = 1'b0;
    step();
    chk_idle("ab");
    chk("ab_dat", 32'(bus.dat), 32'h0A);
    chk("ab_cnt", 32'(bus.sample_cnt), 32'd18);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("ab_hold");
    end
    bus.req = 1'b1;
    wait_rdy(n);
    chk("ab_lat", 32'(n), 32'd5);
    chk("ab_dat_re", 32'(bus.dat), 32'h99);
    chk("ab_cnt_re", 32'(bus.sample_cnt), 32'd19);

    // Write collision on DONE-entry edge (idx=4 holds 93)
    wait_rdy(n);
    chk("col_pre_dat", 32'(bus.dat), 32'h9B);
    repeat (4) step();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 8'hD5;
    step();
    bus.wr_en = 1'b0;
    chk("col_rdy", 32'(bus.rdy), 32'd1);
    chk("col_dat", 32'(bus.dat), 32'h93);
    chk("col_cnt", 32'(bus.sample_cnt), 32'd21);
    mdl[4] = 8'hD5;
    for (int i = 1; i <= 16; i++) begin
      wait_rdy(n);
      chk("col_period", 32'(n), 32'd5);
      chk("col_dat_seq", 32'(bus.dat), 32'(mdl[(4 + i) % 16]));
    end
    chk("col_new", 32'(bus.dat), 32'hD5);
    chk("col_cnt_end", 32'(bus.sample_cnt), 32'd37);

    // Reset mid-CONV with a write pending
    step(); step();
    chk("mr_busy_in", 32'(bus.busy), 32'd1);
    reset = 1'b0; bus.req = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h5A;
    step();
    chk_idle("mr");
    chk("mr_dat", 32'(bus.dat), 32'h00);
    chk("mr_cnt", 32'(bus.sample_cnt), 32'd0);
    reset = 1'b1; bus.wr_en = 1'b0;
    wr(4'd1, 8'h77);
    bus.req = 1'b1;
    wait_rdy(n);
    chk("mr_lat", 32'(n), 32'd5);
    chk("mr_dat0", 32'(bus.dat), 32'h00);
    wait_rdy(n);
    chk("mr_dat1", 32'(bus.dat), 32'h77);
    chk("mr_cnt_end", 32'(bus.sample_cnt), 32'd2);
    wait_rdy(n);
    chk("mr_dat2", 32'(bus.dat), 32'h00);
    bus.req = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
